eh2_dec_gpr_wb_arb: RTL and testbench

Late-writeback arbiter for the per-thread GPR file. It collects register writes from four long-latency requesters (nonblocking-load return, divider, and two spare slots) into per-requester FIFOs. Each cycle it grants up to two of them round-robin onto the two GPR write ports that the primary pipeline leaves idle. It also publishes a per-thread pending-write mask that decode uses to stall dependent reads.

---
 rtl/eh2_dec_gpr_wb_arb.sv | 162 ++++++++++++++++
 tb/tb_eh2_dec_gpr_wb_arb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eh2_dec_gpr_wb_arb.sv
// Late-writeback arbiter for the per-thread GPR file.
// Four long-latency requesters each own a small FIFO; every cycle up to two
// FIFO heads are granted round-robin onto the GPR write ports that the
// primary pipeline leaves idle. A per-thread pending-write mask is published
// so decode can stall reads of registers that still have a queued write.
//
// Handshake: a requester entry is accepted on the clock edge where
// req_valid[i] && req_ready[i]. req_ready is derived from registered state
// only, so a full FIFO never accepts in the same cycle its head pops.
module eh2_dec_gpr_wb_arb #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic [3:0]       req_valid,
    output logic [3:0]       req_ready,
    input  logic [3:0]       req_tid,
    input  logic [3:0][4:0]  req_addr,
    input  logic [3:0][31:0] req_data,
    input  logic [1:0]       port_busy,
    output logic [1:0]       wen,
    output logic [1:0]       wtid,
    output logic [1:0][4:0]  waddr,
    output logic [1:0][31:0] wd,
    output logic [1:0][1:0]  wgnt_id,
    output logic [1:0][31:0] pend_mask,
    input  logic             scan_mode
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] rd_q  [4];
    logic [PW-1:0] wr_q  [4];
    logic [CW-1:0] cnt_q [4];
    logic [1:0]    rr_q, rr_d;

    logic          ent_tid_q  [4][DEPTH];
    logic [4:0]    ent_addr_q [4][DEPTH];
    logic [31:0]   ent_data_q [4][DEPTH];

    logic [3:0]       head_vld, push, pop;
    logic [3:0]       head_tid;
    logic [3:0][4:0]  head_addr;
    logic [3:0][31:0] head_data;

    // scratch for the grant scan
    logic [1:0] sel_n;
    logic       sel_tid;
    logic [4:0] sel_addr;
    logic [1:0] idx;
    logic       first_port;

    // scan_mode has no functional effect
    logic unused_scan;
    assign unused_scan = scan_mode;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    // FIFO status and head fields from registered state
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_ready[i] = (cnt_q[i] < CW'(DEPTH));
            head_vld[i]  = (cnt_q[i] != '0);
            head_tid[i]  = ent_tid_q[i][rd_q[i]];
            head_addr[i] = ent_addr_q[i][rd_q[i]];
            head_data[i] = ent_data_q[i][rd_q[i]];
        end
        push = req_valid & req_ready;
    end

    // Round-robin grant scan: x0 heads drop, first grant to lowest free port,
    // second grant to the other port unless it targets the same {tid, addr}
    always_comb begin
        wen        = '0;
        wtid       = '0;
        waddr      = '0;
        wd         = '0;
        wgnt_id    = '0;
        pop        = '0;
        rr_d       = rr_q;
        sel_n      = 2'd0;
        sel_tid    = 1'b0;
        sel_addr   = '0;
        idx        = '0;
        first_port = port_busy[0];
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (head_vld[idx]) begin
                if (head_addr[idx] == 5'd0) begin
                    pop[idx] = 1'b1;
                end else if (sel_n == 2'd0 && port_busy != 2'b11) begin
                    wen[first_port]     = 1'b1;
                    wtid[first_port]    = head_tid[idx];
                    waddr[first_port]   = head_addr[idx];
                    wd[first_port]      = head_data[idx];
                    wgnt_id[first_port] = idx;
                    pop[idx]            = 1'b1;
                    rr_d                = idx + 2'd1;
                    sel_n               = 2'd1;
                    sel_tid             = head_tid[idx];
                    sel_addr            = head_addr[idx];
                end else if (sel_n == 2'd1 && port_busy == 2'b00 &&
                             !(head_tid[idx] == sel_tid && head_addr[idx] == sel_addr)) begin
                    wen[1]     = 1'b1;
                    wtid[1]    = head_tid[idx];
                    waddr[1]   = head_addr[idx];
                    wd[1]      = head_data[idx];
                    wgnt_id[1] = idx;
                    pop[idx]   = 1'b1;
                    rr_d       = idx + 2'd1;
                    sel_n      = 2'd2;
                end
            end
        end
    end

    // Pending-write mask: OR of every live entry's {tid, addr}; x0 never marks
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if ((((j + DEPTH - int'(rd_q[i])) % DEPTH) < int'(cnt_q[i])) &&
                    (ent_addr_q[i][j] != 5'd0)) begin
                    pend_mask[ent_tid_q[i][j]][ent_addr_q[i][j]] = 1'b1;
                end
            end
        end
    end

    // Pointers, occupancy and round-robin pointer
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < 4; i++) begin
                rd_q[i]  <= '0;
                wr_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wr_q[i] <= ptr_inc(wr_q[i]);
                if (pop[i])  rd_q[i] <= ptr_inc(rd_q[i]);
                if (push[i] && !pop[i])      cnt_q[i] <= cnt_q[i] + CW'(1);
                else if (pop[i] && !push[i]) cnt_q[i] <= cnt_q[i] - CW'(1);
            end
        end
    end

    // Entry storage; contents only matter while covered by the occupancy count
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (push[i]) begin
                ent_tid_q[i][wr_q[i]]  <= req_tid[i];
                ent_addr_q[i][wr_q[i]] <= req_addr[i];
                ent_data_q[i][wr_q[i]] <= req_data[i];
            end
        end
    end
endmodule

// File: tb/tb_eh2_dec_gpr_wb_arb.sv
// Bench for eh2_dec_gpr_wb_arb: directed table, hand sequences and random
// traffic, all checked against a queue-based reference model.
module tb_eh2_dec_gpr_wb_arb;
    localparam int DEPTH = 2;

    logic             clk, rst_l;
    logic [3:0]       req_valid, req_ready, req_tid;
    logic [3:0][4:0]  req_addr;
    logic [3:0][31:0] req_data;
    logic [1:0]       port_busy, wen, wtid;
    logic [1:0][4:0]  waddr;
    logic [1:0][31:0] wd;
    logic [1:0][1:0]  wgnt_id;
    logic [1:0][31:0] pend_mask;
    logic             scan_mode;

    int total, bad;

    typedef struct packed {
        logic        tid;
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    ent_t       mq [4][$];
    int         m_rr;
    logic [3:0] m_pop, m_ready;
    bit         m_any;
    int         m_last;

    typedef struct {
        bit         rst;
        logic [3:0] valid;
        logic [1:0] busy;
        logic [1:0] e_wen;
        logic [4:0] e_a0, e_a1;
        logic [1:0] e_g0, e_g1;
    } row_t;

    eh2_dec_gpr_wb_arb #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid),
        .req_addr(req_addr), .req_data(req_data), .port_busy(port_busy),
        .wen(wen), .wtid(wtid), .waddr(waddr), .wd(wd), .wgnt_id(wgnt_id),
        .pend_mask(pend_mask), .scan_mode(scan_mode)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic clear_reqs();
        req_valid = '0;
        req_tid   = '0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic set_req(input int i, input logic tid, input logic [4:0] addr, input logic [31:0] data);
        req_valid[i] = 1'b1;
        req_tid[i]   = tid;
        req_addr[i]  = addr;
        req_data[i]  = data;
    endtask

    // Reference model: compute this cycle's expected outputs and compare
    task automatic check_now();
        logic [1:0][31:0] e_pend;
        logic [1:0][40:0] e_port;
        int   fp[$];
        int   gn;
        int   i;
        ent_t h, g0;
        #1;
        e_pend = '0; e_port = '0; m_pop = '0; m_ready = '0;
        gn = 0; g0 = '0; m_any = 0; m_last = 0;
        for (int p = 0; p < 2; p++) if (!port_busy[p]) fp.push_back(p);
        for (int q = 0; q < 4; q++) begin
            m_ready[q] = (mq[q].size() < DEPTH);
            for (int j = 0; j < mq[q].size(); j++)
                if (mq[q][j].addr != 0) e_pend[mq[q][j].tid][mq[q][j].addr] = 1'b1;
        end
        for (int k = 0; k < 4; k++) begin
            i = (m_rr + k) % 4;
            if (mq[i].size() == 0) continue;
            h = mq[i][0];
            if (h.addr == 0) begin
                m_pop[i] = 1'b1;
                continue;
            end
            if (gn >= fp.size()) continue;
            if (gn == 1 && h.tid == g0.tid && h.addr == g0.addr) continue;
            e_port[fp[gn]] = {1'b1, h.tid, h.addr, h.data, 2'(i)};
            if (gn == 0) g0 = h;
            gn++;
            m_pop[i] = 1'b1;
            m_last = i;
        end
        m_any = (gn > 0);
        chk("ready", 64'(req_ready), 64'(m_ready));
        chk("port0", 64'({wen[0], wtid[0], waddr[0], wd[0], wgnt_id[0]}), 64'(e_port[0]));
        chk("port1", 64'({wen[1], wtid[1], waddr[1], wd[1], wgnt_id[1]}), 64'(e_port[1]));
        chk("pend_t0", 64'(pend_mask[0]), 64'(e_pend[0]));
        chk("pend_t1", 64'(pend_mask[1]), 64'(e_pend[1]));
    endtask

    // Clock edge: retire pops, accept pushes, advance round-robin pointer
    task automatic tick();
        @(posedge clk);
        for (int q = 0; q < 4; q++) if (m_pop[q]) void'(mq[q].pop_front());
        for (int q = 0; q < 4; q++)
            if (req_valid[q] && m_ready[q])
                mq[q].push_back('{tid: req_tid[q], addr: req_addr[q], data: req_data[q]});
        if (m_any) m_rr = (m_last + 1) % 4;
        @(negedge clk);
    endtask

    // Asynchronous reset pulse mid-cycle, released at a falling edge
    task automatic do_reset();
        #2;
        rst_l = 1'b0;
        clear_reqs();
        for (int q = 0; q < 4; q++) mq[q].delete();
        m_rr = 0;
        #1;
        chk("rst_wen", 64'(wen), 64'(0));
        chk("rst_pend", 64'(pend_mask), 64'(0));
        chk("rst_ready", 64'(req_ready), 64'(4'hF));
        @(negedge clk);
        rst_l = 1'b1;
    endtask

    row_t tbl[14];

    initial begin
        total = 0; bad = 0; m_rr = 0;
        rst_l = 1'b0; port_busy = '0; scan_mode = 1'b0;
        clear_reqs();
        repeat (2) @(negedge clk);
        rst_l = 1'b1;

        // reset state
        check_now();
        chk("init_wen", 64'(wen), 64'(0));
        chk("init_ready", 64'(req_ready), 64'(4'hF));
        chk("init_pend", 64'(pend_mask), 64'(0));
        tick();

        // reset mid-operation with three queued entries
        port_busy = 2'b11;
        set_req(0, 1'b0, 5'd3, 32'h1111_0003);
        set_req(1, 1'b0, 5'd4, 32'h1111_0004);
        set_req(2, 1'b0, 5'd5, 32'h1111_0005);
        check_now(); tick();
        clear_reqs();
        check_now();
        chk("mid_pend", 64'(pend_mask[0]), 64'(32'h0000_0038));
        tick();
        do_reset();
        port_busy = 2'b00;
        check_now();
        chk("post_rst_wen", 64'(wen), 64'(0));
        chk("post_rst_pend", 64'(pend_mask), 64'(0));
        chk("post_rst_ready", 64'(req_ready), 64'(4'hF));
        tick();

        // round-robin table: requester i always writes tid0, addr 8+i
        tbl[0]  = '{1, 4'hF, 2'b00, 2'b00, 5'd0,  5'd0,  2'd0, 2'd0};
        tbl[1]  = '{0, 4'hF, 2'b00, 2'b11, 5'd8,  5'd9,  2'd0, 2'd1};
        tbl[2]  = '{0, 4'hF, 2'b00, 2'b11, 5'd10, 5'd11, 2'd2, 2'd3};
        tbl[3]  = '{0, 4'hF, 2'b00, 2'b11, 5'd8,  5'd9,  2'd0, 2'd1};
        tbl[4]  = '{0, 4'h0, 2'b00, 2'b11, 5'd10, 5'd11, 2'd2, 2'd3};
        tbl[5]  = '{0, 4'h0, 2'b00, 2'b11, 5'd8,  5'd9,  2'd0, 2'd1};
        tbl[6]  = '{0, 4'h0, 2'b00, 2'b11, 5'd10, 5'd11, 2'd2, 2'd3};
        tbl[7]  = '{0, 4'h0, 2'b00, 2'b00, 5'd0,  5'd0,  2'd0, 2'd0};
        tbl[8]  = '{1, 4'hF, 2'b01, 2'b00, 5'd0,  5'd0,  2'd0, 2'd0};
        tbl[9]  = '{0, 4'h0, 2'b01, 2'b10, 5'd0,  5'd8,  2'd0, 2'd0};
        tbl[10] = '{0, 4'h0, 2'b01, 2'b10, 5'd0,  5'd9,  2'd0, 2'd1};
        tbl[11] = '{0, 4'h0, 2'b01, 2'b10, 5'd0,  5'd10, 2'd0, 2'd2};
        tbl[12] = '{0, 4'h0, 2'b01, 2'b10, 5'd0,  5'd11, 2'd0, 2'd3};
        tbl[13] = '{0, 4'h0, 2'b01, 2'b00, 5'd0,  5'd0,  2'd0, 2'd0};
        for (int n = 0; n < 14; n++) begin
            if (tbl[n].rst) do_reset();
            clear_reqs();
            for (int i = 0; i < 4; i++)
                if (tbl[n].valid[i]) set_req(i, 1'b0, 5'(8 + i), 32'hC0DE_0000 + 32'(i));
            port_busy = tbl[n].busy;
            check_now();
            chk($sformatf("tbl%0d_wen", n), 64'(wen), 64'(tbl[n].e_wen));
            chk($sformatf("tbl%0d_waddr", n), 64'(waddr), 64'({tbl[n].e_a1, tbl[n].e_a0}));
            chk($sformatf("tbl%0d_gnt", n), 64'(wgnt_id), 64'({tbl[n].e_g1, tbl[n].e_g0}));
            tick();
        end

        // single request, one-cycle latency
        do_reset();
        port_busy = 2'b00;
        set_req(0, 1'b0, 5'd5, 32'hDEAD_BEEF);
        check_now(); tick();
        clear_reqs();
        check_now();
        chk("single_wen", 64'(wen), 64'(2'b01));
        chk("single_addr", 64'(waddr[0]), 64'(5'd5));
        chk("single_data", 64'(wd[0]), 64'(32'hDEAD_BEEF));
        chk("single_pend_on", 64'(pend_mask[0][5]), 64'(1));
        tick();
        check_now();
        chk("single_pend_off", 64'(pend_mask[0][5]), 64'(0));
        chk("single_idle", 64'(wen), 64'(0));
        tick();

        // collision on {tid1, a7}
        do_reset();
        set_req(0, 1'b1, 5'd7, 32'hAAAA_0000);
        set_req(1, 1'b1, 5'd7, 32'hBBBB_0001);
        set_req(2, 1'b0, 5'd7, 32'hCCCC_0002);
        check_now(); tick();
        clear_reqs();
        check_now();
        chk("coll_wen", 64'(wen), 64'(2'b11));
        chk("coll_gnt", 64'(wgnt_id), 64'({2'd2, 2'd0}));
        chk("coll_pend", 64'(pend_mask[1][7]), 64'(1));
        tick();
        check_now();
        chk("coll2_wen", 64'(wen), 64'(2'b01));
        chk("coll2_gnt", 64'(wgnt_id[0]), 64'(2'd1));
        chk("coll2_data", 64'(wd[0]), 64'(32'hBBBB_0001));
        tick();
        check_now();
        chk("coll3_pend", 64'(pend_mask[1]), 64'(0));
        tick();

        // full FIFO backpressure with both ports busy
        do_reset();
        port_busy = 2'b11;
        set_req(2, 1'b0, 5'd1, 32'hF000_0001);
        check_now(); tick();
        set_req(2, 1'b0, 5'd2, 32'hF000_0002);
        check_now(); tick();
        set_req(2, 1'b0, 5'd3, 32'hF000_0003);
        check_now();
        chk("full_ready", 64'(req_ready[2]), 64'(0));
        chk("full_nowen", 64'(wen), 64'(0));
        tick();
        port_busy = 2'b00;
        check_now();
        chk("drain1_ready", 64'(req_ready[2]), 64'(0));
        chk("drain1", 64'({wen, waddr[0], wgnt_id[0]}), 64'({2'b01, 5'd1, 2'd2}));
        tick();
        check_now();
        chk("drain2_ready", 64'(req_ready[2]), 64'(1));
        chk("drain2", 64'(waddr[0]), 64'(5'd2));
        tick();
        clear_reqs();
        check_now();
        chk("drain3", 64'({waddr[0], wd[0]}), 64'({5'd3, 32'hF000_0003}));
        tick();
        check_now();
        chk("drain_done", 64'(wen), 64'(0));
        tick();

        // x0 drop
        do_reset();
        set_req(3, 1'b0, 5'd0, 32'h0000_0BAD);
        check_now(); tick();
        set_req(3, 1'b0, 5'd4, 32'h0000_0004);
        check_now();
        chk("x0_nowen", 64'(wen), 64'(0));
        chk("x0_pend", 64'(pend_mask[0]), 64'(0));
        tick();
        clear_reqs();
        check_now();
        chk("x0_next", 64'({wen, waddr[0], wgnt_id[0]}), 64'({2'b01, 5'd4, 2'd3}));
        chk("x0_pend4", 64'(pend_mask[0]), 64'(32'h10));
        tick();

        // random traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            req_valid = 4'($urandom);
            req_tid   = 4'($urandom);
            for (int i = 0; i < 4; i++) begin
                req_addr[i] = 5'($urandom_range(0, 7));
                req_data[i] = $urandom;
            end
            port_busy = 2'($urandom_range(0, 3));
            scan_mode = 1'($urandom);
            check_now();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
